// File: rtl/pc_ir_datapath.sv
// Multicycle MIPS datapath front-end: PC, IR, MDR and ALUOut registers plus a
// wait-state fetch FSM. Optional IR-capture counter under macro INSTR_COUNT_EN.
module pc_ir_datapath #(
    parameter int          Data_Width       = 32,
    parameter int          Opcode_Size      = 6,
    parameter int          Rtypr_Funct_Size = 6,
    parameter logic [31:0] Reset_PC         = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        PCWrite,
    input  logic                        Branch,
    input  logic                        Zero,
    input  logic [1:0]                  PCSrc,
    input  logic                        IorD,
    input  logic                        IRWrite,
    input  logic [Data_Width-1:0]       ALUResult,
    input  logic [Data_Width-1:0]       MemRData,
    input  logic                        MemReady,
    output logic [Data_Width-1:0]       MemAdr,
    output logic [Data_Width-1:0]       PC,
    output logic [Data_Width-1:0]       Instr,
    output logic [Opcode_Size-1:0]      Opcode,
    output logic [Rtypr_Funct_Size-1:0] Funct,
    output logic [4:0]                  Rs,
    output logic [4:0]                  Rt,
    output logic [4:0]                  Rd,
    output logic [Data_Width-1:0]       SignImm,
    output logic [Data_Width-1:0]       MDR,
    output logic [Data_Width-1:0]       ALUOut,
    output logic                        Stall,
    output logic                        dbg_fetch_state
`ifdef INSTR_COUNT_EN
   ,output logic [31:0]                 InstrCount
`endif
);

    // Handshake: MemRData is accepted on a rising edge only when MemReady=1 in
    // that cycle; while a fetch is outstanding and MemReady=0, Stall=1 tells the
    // control FSM to hold all of its outputs until the data arrives.
    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetch_state_t;

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic                  w_stall;
    logic                  w_ir_load;
    logic                  w_pc_en;
    logic [Data_Width-1:0] w_pc_next;
    logic [Data_Width-1:0] w_jump_target;
    logic [Data_Width-1:0] r_pc;
    logic [Data_Width-1:0] r_instr;
    logic [Data_Width-1:0] r_mdr;
    logic [Data_Width-1:0] r_aluout;

    // ---------------- fetch FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- fetch FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            F_IDLE: begin
                if (IRWrite && !MemReady) begin
                    w_next_state = F_WAIT;
                end
            end
            F_WAIT: begin
                if (MemReady) begin
                    w_next_state = F_IDLE;
                end
            end
            default: w_next_state = F_IDLE;
        endcase
    end

    // ---------------- fetch FSM: outputs ----------------
    // IRWrite is only honoured from F_IDLE; in F_WAIT the pending fetch owns the IR.
    always_comb begin
        w_stall   = 1'b0;
        w_ir_load = 1'b0;
        case (r_state)
            F_IDLE: begin
                w_stall   = IRWrite & ~MemReady;
                w_ir_load = IRWrite & MemReady;
            end
            F_WAIT: begin
                w_stall   = ~MemReady;
                w_ir_load = MemReady;
            end
            default: begin
                w_stall   = 1'b0;
                w_ir_load = 1'b0;
            end
        endcase
    end

    // ---------------- PC ----------------
    assign w_pc_en       = PCWrite | (Branch & Zero);
    assign w_jump_target = {r_pc[Data_Width-1:28], r_instr[25:0], 2'b00};

    always_comb begin
        w_pc_next = r_pc;
        case (PCSrc)
            2'b00:   w_pc_next = ALUResult;
            2'b01:   w_pc_next = r_aluout;
            2'b10:   w_pc_next = w_jump_target;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= Reset_PC[Data_Width-1:0];
        end else if (w_pc_en && !w_stall) begin
            r_pc <= w_pc_next;
        end
    end

    // ---------------- IR, MDR, ALUOut ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr <= '0;
        end else if (w_ir_load) begin
            r_instr <= MemRData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mdr <= '0;
        end else if (MemReady) begin
            r_mdr <= MemRData;
        end
    end

    // ALUOut freezes with the control FSM so a stalled multi-cycle op keeps its operand.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_aluout <= '0;
        end else if (!w_stall) begin
            r_aluout <= ALUResult;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr_count <= '0;
        end else if (w_ir_load) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign InstrCount = r_instr_count;
`endif

    // ---------------- outputs and field decode ----------------
    assign MemAdr          = IorD ? r_aluout : r_pc;
    assign PC              = r_pc;
    assign Instr           = r_instr;
    assign MDR             = r_mdr;
    assign ALUOut          = r_aluout;
    assign Stall           = w_stall;
    assign dbg_fetch_state = r_state;

    assign Opcode  = r_instr[31 -: Opcode_Size];
    assign Funct   = r_instr[Rtypr_Funct_Size-1:0];
    assign Rs      = r_instr[25:21];
    assign Rt      = r_instr[20:16];
    assign Rd      = r_instr[15:11];
    assign SignImm = {{(Data_Width-16){r_instr[15]}}, r_instr[15:0]};

endmodule

// File: tb/tb_pc_ir_datapath.sv
// Directed and randomized bench for pc_ir_datapath against a cycle-level
// reference model built from the architectural rules.
module tb_pc_ir_datapath;

    logic        clk;
    logic        rst;
    logic        PCWrite, Branch, Zero, IorD, IRWrite, MemReady;
    logic [1:0]  PCSrc;
    logic [31:0] ALUResult, MemRData;
    logic [31:0] MemAdr, PC, Instr, SignImm, MDR, ALUOut;
    logic [5:0]  Opcode, Funct;
    logic [4:0]  Rs, Rt, Rd;
    logic        Stall;
    logic        dbg_fetch_state;
`ifdef INSTR_COUNT_EN
    logic [31:0] InstrCount;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_mdr, m_aluout, m_count;
    bit          m_waiting;

    pc_ir_datapath dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .Zero(Zero),
        .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .ALUResult(ALUResult),
        .MemRData(MemRData), .MemReady(MemReady), .MemAdr(MemAdr), .PC(PC),
        .Instr(Instr), .Opcode(Opcode), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .SignImm(SignImm), .MDR(MDR), .ALUOut(ALUOut), .Stall(Stall),
        .dbg_fetch_state(dbg_fetch_state)
`ifdef INSTR_COUNT_EN
       ,.InstrCount(InstrCount)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_stall();
        return !MemReady && (IRWrite || m_waiting);
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] old_pc, old_instr, old_aluout;
        bit          stall, fetching;
        if (!rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_mdr = 32'h0; m_aluout = 32'h0;
            m_count = 32'h0; m_waiting = 0;
            return;
        end
        old_pc = m_pc; old_instr = m_instr; old_aluout = m_aluout;
        fetching = IRWrite || m_waiting;
        stall    = !MemReady && fetching;
        if ((PCWrite || (Branch && Zero)) && !stall) begin
            if (PCSrc == 2'd0)      m_pc = ALUResult;
            else if (PCSrc == 2'd1) m_pc = old_aluout;
            else if (PCSrc == 2'd2) m_pc = (old_pc & 32'hF000_0000) | ((old_instr & 32'h03FF_FFFF) * 4);
        end
        if (MemReady && fetching) begin
            m_instr = MemRData;
            m_count = m_count + 1;
        end
        m_waiting = !MemReady && fetching;
        if (MemReady) m_mdr = MemRData;
        if (!stall) m_aluout = ALUResult;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] sext;
        sext = 32'($signed(m_instr[15:0]));
        check({tag, ".PC"},      PC,      m_pc);
        check({tag, ".Instr"},   Instr,   m_instr);
        check({tag, ".MDR"},     MDR,     m_mdr);
        check({tag, ".ALUOut"},  ALUOut,  m_aluout);
        check({tag, ".Opcode"},  {26'h0, Opcode}, m_instr / 32'h0400_0000);
        check({tag, ".Funct"},   {26'h0, Funct},  m_instr % 64);
        check({tag, ".Rs"},      {27'h0, Rs},     (m_instr / 32'h20_0000) % 32);
        check({tag, ".Rt"},      {27'h0, Rt},     (m_instr / 32'h1_0000) % 32);
        check({tag, ".Rd"},      {27'h0, Rd},     (m_instr / 32'h800) % 32);
        check({tag, ".SignImm"}, SignImm, sext);
        check({tag, ".state"},   {31'h0, dbg_fetch_state}, {31'h0, m_waiting});
`ifdef INSTR_COUNT_EN
        check({tag, ".InstrCount"}, InstrCount, m_count);
`endif
    endtask

    // One clock: check combinational outputs, take the edge, check registers.
    task automatic step(input string tag);
        #1;
        check({tag, ".Stall"},  {31'h0, Stall}, {31'h0, model_stall()});
        check({tag, ".MemAdr"}, MemAdr, IorD ? m_aluout : m_pc);
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
    endtask

    task automatic drive_idle();
        rst = 1'b1; PCWrite = 1'b0; Branch = 1'b0; Zero = 1'b0; PCSrc = 2'd3;
        IorD = 1'b0; IRWrite = 1'b0; MemReady = 1'b0;
        ALUResult = $urandom; MemRData = $urandom;
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_mdr = 0; m_aluout = 0; m_count = 0; m_waiting = 0;

        // Reset held two cycles with PCWrite active
        drive_idle();
        rst = 1'b0; PCWrite = 1'b1; PCSrc = 2'd0;
        @(posedge clk); model_edge(); #1;
        step("reset");
        rst = 1'b1; PCWrite = 1'b0; PCSrc = 2'd3;
        #1;
        check("reset.PC", PC, 32'h0);
        check("reset.Instr", Instr, 32'h0);
        check("reset.Stall", {31'h0, Stall}, 32'h0);

        // Zero-wait fetch
        drive_idle();
        MemRData = 32'h8C22_0004; IRWrite = 1'b1; MemReady = 1'b1;
        PCWrite = 1'b1; PCSrc = 2'd0; ALUResult = 32'd4;
        step("fetch0");
        check("fetch0.Instr", Instr, 32'h8C22_0004);
        check("fetch0.Opcode", {26'h0, Opcode}, 32'h23);
        check("fetch0.Rt", {27'h0, Rt}, 32'd2);
        check("fetch0.SignImm", SignImm, 32'd4);
        check("fetch0.PC", PC, 32'd4);

        // Wait-state fetch: three stalled cycles then data
        drive_idle();
        IRWrite = 1'b1; MemReady = 1'b0; PCWrite = 1'b1; PCSrc = 2'd0;
        for (int i = 0; i < 3; i++) begin
            ALUResult = $urandom;
            #1;
            check("wait.Stall_hi", {31'h0, Stall}, 32'd1);
            step("wait");
            check("wait.PC_hold", PC, 32'd4);
            check("wait.Instr_hold", Instr, 32'h8C22_0004);
        end
        MemReady = 1'b1; MemRData = 32'h0000_2820; PCWrite = 1'b0; IRWrite = 1'b0;
        #1;
        check("wait.Stall_lo", {31'h0, Stall}, 32'd0);
        step("wait_done");
        check("wait_done.Instr", Instr, 32'h0000_2820);

        // Branch via ALUOut = 0x40
        drive_idle();
        ALUResult = 32'h40;
        step("br_load");
        drive_idle();
        Branch = 1'b1; Zero = 1'b1; PCSrc = 2'd1;
        step("br_taken");
        check("br_taken.PC", PC, 32'h40);
        drive_idle();
        ALUResult = 32'h80;
        step("br_load2");
        drive_idle();
        Branch = 1'b1; Zero = 1'b0; PCSrc = 2'd1;
        step("br_not");
        check("br_not.PC", PC, 32'h40);

        // Jump: PC=1000_0008, Instr=0800_0010
        drive_idle();
        PCWrite = 1'b1; PCSrc = 2'd0; ALUResult = 32'h1000_0008;
        IRWrite = 1'b1; MemReady = 1'b1; MemRData = 32'h0800_0010;
        step("j_setup");
        drive_idle();
        PCWrite = 1'b1; PCSrc = 2'd2;
        step("jump");
        check("jump.PC", PC, 32'h1000_0040);

        // Reset while waiting on memory
        drive_idle();
        IRWrite = 1'b1; MemReady = 1'b0;
        step("rw_enter");
        check("rw_enter.state", {31'h0, dbg_fetch_state}, 32'd1);
        drive_idle();
        rst = 1'b0; MemReady = 1'b0;
        step("rw_reset");
        rst = 1'b1;
        #1;
        check("rw_reset.state", {31'h0, dbg_fetch_state}, 32'd0);
        check("rw_reset.Stall", {31'h0, Stall}, 32'd0);
        check("rw_reset.PC", PC, 32'h0);
`ifdef INSTR_COUNT_EN
        check("rw_reset.InstrCount", InstrCount, 32'h0);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) != 0);
            PCWrite   = $urandom_range(0, 1);
            Branch    = $urandom_range(0, 1);
            Zero      = $urandom_range(0, 1);
            PCSrc     = 2'($urandom_range(0, 3));
            IorD      = $urandom_range(0, 1);
            IRWrite   = ($urandom_range(0, 2) == 0);
            MemReady  = ($urandom_range(0, 2) != 0);
            ALUResult = $urandom;
            MemRData  = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
